// File: rtl/rsa_ctrl_pkg.sv
// Shared types and constants for the RSA modular-exponentiation loop controller.
// The bench monitor imports the same state enum.
package rsa_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SQ   = 3'd2,
    S_MUL  = 3'd3,
    S_NEXT = 3'd4,
    S_POST = 3'd5
  } state_t;

  localparam logic MM_OP_SQUARE = 1'b0;
  localparam logic MM_OP_MULT   = 1'b1;

  // Bit-index width for an exponent of w bits; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w < 32'd2) ? 32'd1 : 32'($clog2(w));
  endfunction

endpackage

// File: rtl/modexp_loop_ctrl.sv
// Square-and-multiply sequencer: scans a latched exponent MSB-first and issues
// one square per bit plus a multiply per set bit to the shared modular multiplier.
module modexp_loop_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = 32,
  parameter int unsigned IDX_W     = idx_width(EXP_WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 mm_start,
  output logic                 mm_op,
  input  logic                 mm_done,
  output logic                 busy,
  output logic [2:0]           cur_state,
  output logic [IDX_W-1:0]     bit_idx,
  output logic                 iter_start,
  output logic                 iter_end,
  output logic                 finish
);

  state_t               state_q, state_d, state_dec;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 first_q;
  logic                 done_ok;

  // A done in the same cycle as the request cannot belong to it.
  assign done_ok = mm_done && !first_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PRE;
      S_PRE:  state_d = (exp_q == '0) ? S_POST : S_SQ;
      S_SQ:   if (done_ok) state_d = exp_q[idx_q] ? S_MUL : S_NEXT;
      S_MUL:  if (done_ok) state_d = S_NEXT;
      S_NEXT: state_d = (idx_q == '0) ? S_POST : S_SQ;
      S_POST: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q) && (state_d == S_SQ || state_d == S_MUL);
      if (state_q == S_IDLE && start) begin
        exp_q <= exp;
        idx_q <= IDX_W'(EXP_WIDTH - 1);
      end else if (state_q == S_NEXT && idx_q != '0) begin
        idx_q <= idx_q - IDX_W'(1);
      end
    end
  end

  // Unused encodings present as IDLE on every output.
  assign state_dec  = (state_q > S_POST) ? S_IDLE : state_q;

  assign mm_start   = first_q && (state_dec == S_SQ || state_dec == S_MUL);
  assign mm_op      = (state_dec == S_MUL) ? MM_OP_MULT : MM_OP_SQUARE;
  assign busy       = (state_dec != S_IDLE);
  assign cur_state  = state_dec;
  assign bit_idx    = idx_q;
  assign iter_start = first_q && (state_dec == S_SQ);
  assign iter_end   = (state_dec == S_NEXT);
  assign finish     = (state_dec == S_POST);

endmodule

// File: tb/tb_modexp_loop_ctrl.sv
// Directed bench for modexp_loop_ctrl with a fixed-latency multiplier model.
module tb_modexp_loop_ctrl;
  import rsa_ctrl_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned IW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  exp_in;
  logic          mm_start, mm_op, mm_done;
  logic          busy, iter_start, iter_end, finish;
  logic [2:0]    cur_state;
  logic [IW-1:0] bit_idx;

  logic model_done = 1'b0;
  logic stray_done = 1'b0;
  assign mm_done = model_done | stray_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int cnt = 0;
  logic ops[$];
  int   idx_log[$];
  int   n_is = 0, n_ie = 0, n_fin = 0;

  modexp_loop_ctrl #(.EXP_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .exp(exp_in),
    .mm_start(mm_start), .mm_op(mm_op), .mm_done(mm_done),
    .busy(busy), .cur_state(cur_state), .bit_idx(bit_idx),
    .iter_start(iter_start), .iter_end(iter_end), .finish(finish)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Multiplier model: done arrives lat cycles after the request cycle.
  always @(negedge clock) begin
    model_done = 1'b0;
    if (reset) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) model_done = 1'b1;
      end
      if (mm_start) cnt = lat;
    end
    if (mm_start) ops.push_back(mm_op);
    if (iter_start) begin n_is++; idx_log.push_back(int'(bit_idx)); end
    if (iter_end) n_ie++;
    if (finish) n_fin++;
  end

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, int'({mm_start, mm_op, busy, cur_state, bit_idx, iter_start, iter_end, finish}), 0);
  endtask

  task automatic run_case(input string tag, input logic [W-1:0] e, input int l,
                          input bit poke, input bit stray,
                          input int fin_w, input int nreq_w, input int ops_w,
                          input int iter_w, input int idx_w);
    int t, fin, nb, b_ops, b_is, b_ie, b_idx, got;
    bit seen;
    @(negedge clock);
    chk({tag, "_idle"}, int'({busy, cur_state}), 0);
    lat = l;
    b_ops = ops.size(); b_is = n_is; b_ie = n_ie; b_idx = idx_log.size();
    start = 1'b1; exp_in = e; t = cyc; fin = -1; nb = 0; seen = 1'b0;
    for (int i = 0; i < 300 && fin < 0; i++) begin
      @(negedge clock);
      start = 1'b0;
      stray_done = 1'b0;
      if (busy) nb++;
      if (finish) fin = cyc - t;
      if (mm_start && !seen) begin
        seen = 1'b1;
        if (poke) begin start = 1'b1; exp_in = ~e; end
        if (stray) stray_done = 1'b1;
      end
    end
    start = 1'b0;
    stray_done = 1'b0;
    chk({tag, "_finish_cycle"}, fin, fin_w);
    chk({tag, "_busy_cycles"}, nb, fin_w);
    chk({tag, "_nreq"}, ops.size() - b_ops, nreq_w);
    got = 0;
    for (int i = b_ops; i < ops.size(); i++) got |= int'(ops[i]) << (i - b_ops);
    chk({tag, "_op_seq"}, got, ops_w);
    chk({tag, "_iter_start"}, n_is - b_is, iter_w);
    chk({tag, "_iter_end"}, n_ie - b_ie, iter_w);
    got = 0;
    for (int i = b_idx; i < idx_log.size(); i++) got = got * 4 + idx_log[i];
    chk({tag, "_idx_seq"}, got, idx_w);
  endtask

  initial begin
    int b_ops, b_fin;
    bit in_mul;
    reset = 1'b1; start = 1'b0; exp_in = '0;
    repeat (3) @(negedge clock);
    chk_quiet("reset_outputs");
    reset = 1'b0;

    // Op sequences packed LSB-first (1 = multiply); idx sequence base-4 in order.
    run_case("exp0",   4'b0000, 3, 1'b0, 1'b0,  2, 0,   0, 0,   0);
    run_case("b1011",  4'b1011, 3, 1'b0, 1'b0, 34, 7,  82, 4, 228);
    run_case("b1111",  4'b1111, 1, 1'b0, 1'b0, 22, 8, 170, 4, 228);
    run_case("poke",   4'b0101, 2, 1'b1, 1'b0, 24, 6,  36, 4, 228);

    @(negedge clock);
    stray_done = 1'b1;
    @(negedge clock);
    stray_done = 1'b0;
    chk_quiet("stray_idle");

    run_case("coinc",  4'b1000, 2, 1'b0, 1'b1, 21, 5,   2, 4, 228);

    // Reset while a multiply is outstanding.
    @(negedge clock);
    lat = 3; exp_in = 4'b1011; start = 1'b1;
    in_mul = 1'b0;
    for (int i = 0; i < 100 && !in_mul; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (cur_state == S_MUL) in_mul = 1'b1;
    end
    chk("reach_mul", int'(in_mul), 1);
    reset = 1'b1;
    @(negedge clock);
    chk_quiet("reset_in_mul");
    reset = 1'b0;
    b_ops = ops.size(); b_fin = n_fin;
    repeat (6) @(negedge clock);
    chk("post_reset_req", ops.size() - b_ops, 0);
    chk("post_reset_fin", n_fin - b_fin, 0);
    chk("post_reset_state", int'(cur_state), int'(S_IDLE));

    run_case("after_rst", 4'b1011, 1, 1'b0, 1'b0, 20, 7, 82, 4, 228);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
